// File: rtl/platform_ram_copier_pkg.sv
// Shared types and defaults for the platform RAM block copier.
// Optional checksum logic in the top is enabled by PLATFORM_RAM_COPIER_CHECKSUM_EN.
package platform_copier_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWt,
        StWr,
        StDn
    } copier_state_e;

    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned DATA_W_DEF = 32;
    localparam logic [DATA_W_DEF/8-1:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/platform_ram_copier.sv
// Avalon-MM master that copies words one at a time (read, wait, write) within the platform RAM.
// Define PLATFORM_RAM_COPIER_CHECKSUM_EN to build the XOR checksum of written words.
module platform_ram_copier
    import platform_copier_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     len_words,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   checksum,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic                m_clken
);

    localparam logic [2:0] WaitInit = 3'(READ_LATENCY - 1);

    copier_state_e     state;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W:0]   remaining;
    logic [2:0]        wait_cnt;

`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign m_byteenable = '1;
    assign m_clken      = ~reset;

    // m_writedata doubles as the captured-word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= StIdle;
            src          <= '0;
            dst          <= '0;
            remaining    <= '0;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= len_words;
                        busy      <= 1'b1;
`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
                        checksum_q <= '0;
`endif
                        if (len_words == '0) begin
                            state <= StDn;
                            done  <= 1'b1;
                        end else begin
                            state        <= StRd;
                            m_chipselect <= 1'b1;
                            m_write      <= 1'b0;
                            m_address    <= src_addr;
                        end
                    end
                end
                StRd: begin
                    state        <= StWt;
                    m_chipselect <= 1'b0;
                    wait_cnt     <= WaitInit;
                end
                StWt: begin
                    if (wait_cnt == '0) begin
                        state        <= StWr;
                        m_chipselect <= 1'b1;
                        m_write      <= 1'b1;
                        m_address    <= dst;
                        m_writedata  <= m_readdata;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                StWr: begin
                    src       <= src + 1'b1;
                    dst       <= dst + 1'b1;
                    remaining <= remaining - 1'b1;
                    m_write   <= 1'b0;
`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
                    checksum_q <= checksum_q ^ m_writedata;
`endif
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state        <= StDn;
                        m_chipselect <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        // Next read issues straight from the incremented source.
                        state        <= StRd;
                        m_chipselect <= 1'b1;
                        m_address    <= src + 1'b1;
                    end
                end
                StDn: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_ram_copier.sv
// Self-checking bench for platform_ram_copier: RAM model, table of directed copies, random copies.
// Checksum expectations follow PLATFORM_RAM_COPIER_CHECKSUM_EN.
module tb_platform_ram_copier;

    localparam int RL    = 1;
    localparam int WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [12:0] len_words;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [11:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        m_clken;

    platform_ram_copier #(.ADDR_W(12), .DATA_W(32), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len_words    (len_words),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_clken      (m_clken)
    );

    always #5 clk = ~clk;

    // RAM model and its preload paths
    logic [31:0] mem [WORDS];
    logic [31:0] rd_pipe [RL];
    logic        fill;
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;
    int          viol;

    function automatic logic [31:0] fill_val(int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    assign m_readdata = rd_pipe[RL-1];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= fill_val(i);
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (m_clken && m_chipselect && m_write) begin
            mem[m_address] <= m_writedata;
        end
        if (m_clken && m_chipselect && !m_write) rd_pipe[0] <= mem[m_address];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (!m_chipselect && m_write) viol <= viol + 1;
    end

    // Reference model: the RAM contents as the specification says they should be
    logic [31:0] ref_mem [WORDS];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_copy(int s, int d, int l);
        logic [31:0] x = '0;
        for (int i = 0; i < l; i++) begin
            logic [31:0] v = ref_mem[(s + i) % WORDS];
            ref_mem[(d + i) % WORDS] = v;
            x ^= v;
        end
`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
        return x;
`else
        return 32'h0;
`endif
    endfunction

    task automatic compare_mem(input string name);
        int bad = 0;
        for (int i = 0; i < WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(name, 32'(bad), 32'h0);
    endtask

    task automatic poke(input int a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 12'(a); pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
        ref_mem[a % WORDS] = d;
    endtask

    // Cycle 0 is the cycle start is high; done_cyc is the cycle done is seen.
    task automatic run_copy(input int s, input int d, input int l, input int poke_at,
                            output int done_cyc, output int cs_cnt);
        int bound = l * (2 + RL) + 10;
        done_cyc = -1;
        cs_cnt   = 0;
        @(negedge clk);
        start = 1'b1; src_addr = 12'(s); dst_addr = 12'(d); len_words = 13'(l);
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_at != 0 && n == poke_at) begin
                start = 1'b1; src_addr = 12'(s + 7); dst_addr = 12'(d + 9); len_words = 13'd5;
            end
            if (m_chipselect) cs_cnt++;
            if (done && done_cyc < 0) done_cyc = n;
            if (done_cyc >= 0 && n == done_cyc + 1) begin
                check("busy_after_done", {31'b0, busy}, 32'h0);
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int              src;
        int              dst;
        int              len;
        int              npre;
        logic [3:0][31:0] pre;
        int              poke_at;
        int              exp_cyc;
        bit              chk_known;
        logic [31:0]     exp_chk;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int dc, cs, s, d, l;
        logic [31:0] mchk, echk;

        vecs[0] = '{0, 100, 4, 4, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                    0, 13, 1'b1, 32'h44444444};
        vecs[1] = '{5, 6, 0, 0, '0, 0, 1, 1'b1, 32'h0};
        vecs[2] = '{4094, 10, 4, 0, '0, 0, 13, 1'b0, 32'h0};
        vecs[3] = '{0, 1, 3, 2, {32'h0, 32'h0, 32'hB, 32'hA}, 0, 10, 1'b1, 32'hA};
        vecs[4] = '{500, 600, 2, 2, {32'h0, 32'h0, 32'hFFFF0000, 32'h0F0F0F0F},
                    2, 7, 1'b1, 32'hF0F00F0F};

        viol = 0;
        reset = 1'b1; start = 1'b0; fill = 1'b0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0; src_addr = '0; dst_addr = '0; len_words = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   {31'b0, busy}, 32'h0);
        check("rst_done",   {31'b0, done}, 32'h0);
        check("rst_cs",     {31'b0, m_chipselect}, 32'h0);
        check("rst_write",  {31'b0, m_write}, 32'h0);
        check("rst_addr",   {20'b0, m_address}, 32'h0);
        check("rst_wdata",  m_writedata, 32'h0);
        check("rst_chk",    checksum, 32'h0);
        check("rst_clken",  {31'b0, m_clken}, 32'h0);
        check("byteenable", {28'b0, m_byteenable}, 32'hF);

        reset = 1'b0; fill = 1'b1;
        @(negedge clk);
        fill = 1'b0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = fill_val(i);
        check("clken_run", {31'b0, m_clken}, 32'h1);

        foreach (vecs[k]) begin
            for (int j = 0; j < vecs[k].npre; j++) poke(vecs[k].src + j, vecs[k].pre[j]);
            run_copy(vecs[k].src, vecs[k].dst, vecs[k].len, vecs[k].poke_at, dc, cs);
            mchk = ref_copy(vecs[k].src, vecs[k].dst, vecs[k].len);
`ifdef PLATFORM_RAM_COPIER_CHECKSUM_EN
            echk = vecs[k].chk_known ? vecs[k].exp_chk : mchk;
`else
            echk = 32'h0;
`endif
            check($sformatf("vec%0d_done_cycle", k), 32'(dc), 32'(vecs[k].exp_cyc));
            check($sformatf("vec%0d_cs_count", k), 32'(cs), 32'(2 * vecs[k].len));
            check($sformatf("vec%0d_checksum", k), checksum, echk);
            compare_mem($sformatf("vec%0d_mem", k));
        end

        // Reset during the wait of word 2 of an 8-word copy
        @(negedge clk);
        start = 1'b1; src_addr = 12'd200; dst_addr = 12'd300; len_words = 13'd8;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy",  {31'b0, busy}, 32'h0);
        check("midrst_cs",    {31'b0, m_chipselect}, 32'h0);
        check("midrst_done",  {31'b0, done}, 32'h0);
        check("midrst_clken", {31'b0, m_clken}, 32'h0);
        reset = 1'b0;
        cs = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) cs++;
        end
        check("midrst_quiet", 32'(cs), 32'h0);
        void'(ref_copy(200, 300, 1));
        compare_mem("midrst_mem");
        run_copy(200, 300, 8, 0, dc, cs);
        mchk = ref_copy(200, 300, 8);
        check("post_rst_done_cycle", 32'(dc), 32'd25);
        check("post_rst_checksum", checksum, mchk);
        compare_mem("post_rst_mem");

        // Random copies, half of them with nearby (often overlapping) destinations
        for (int it = 0; it < 24; it++) begin
            s = int'($urandom_range(0, WORDS - 1));
            d = ($urandom_range(0, 1) == 1) ? (s + int'($urandom_range(0, 30))) % WORDS
                                            : int'($urandom_range(0, WORDS - 1));
            l = int'($urandom_range(0, 24));
            run_copy(s, d, l, 0, dc, cs);
            mchk = ref_copy(s, d, l);
            check($sformatf("rnd%0d_done_cycle", it), 32'(dc), 32'(l * (2 + RL) + 1));
            check($sformatf("rnd%0d_cs_count", it), 32'(cs), 32'(2 * l));
            check($sformatf("rnd%0d_checksum", it), checksum, mchk);
            compare_mem($sformatf("rnd%0d_mem", it));
        end

        check("write_without_cs", 32'(viol), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/platform_ram_copier.md
Name: platform_ram_copier

Overview:
- Avalon-MM master that copies a block of 32-bit words from one region of the on-chip platform RAM to another.
- Connects point-to-point to the RAM's single-port slave: address, byteenable, chipselect, write, writedata, readdata and clken.
- Started by a one-cycle command from the control processor; reports busy and a done pulse.
- Words are moved strictly one at a time, each as a read, then a wait, then a write.

Parameters:
- ADDR_W, 12, word-address width of the RAM port (4096 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from the read-command edge to readdata valid. Legal range is 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; latched on an accepted start.
- dst_addr  in  ADDR_W  first destination word address; latched on an accepted start.
- len_words  in  ADDR_W+1  number of words to copy, 0..4096; latched on an accepted start.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse when the copy completes.
- checksum  out  DATA_W  XOR of all words written (see Optional Feature).
- m_address  out  ADDR_W  RAM word address.
- m_byteenable  out  DATA_W/8  always all ones.
- m_chipselect  out  1  RAM access strobe.
- m_write  out  1  write qualifier; a read when low with chipselect high.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  RAM read data.
- m_clken  out  1  RAM clock enable; 0 during reset, 1 otherwise.

Behaviour:
- Reset (synchronous): at the first edge with reset high, the block goes to IDLE.
  - Outputs: busy=0, done=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, checksum=0, m_clken=0.
  - Latched src, dst and remaining count are cleared.
  - Reset mid-transfer abandons the transfer. No done pulse. Words already written stay written.
- FSM states: IDLE, RD, WT, WR, DN.
- IDLE:
  - On start=1, latch src/dst/len and go to RD if len≠0, or to DN if len=0.
  - start outside IDLE is ignored; no queuing.
- RD (1 cycle): m_chipselect=1, m_write=0, m_address=src. Go to WT.
- WT (READ_LATENCY cycles):
  - m_chipselect=0.
  - Wait counter counts down from READ_LATENCY-1.
  - m_readdata is captured into the data register on the edge ending the last WT cycle. Go to WR.
- WR (1 cycle):
  - m_chipselect=1, m_write=1, m_address=dst, m_writedata=captured word.
  - On exit: src+1 and dst+1, both modulo 2^ADDR_W, so address 4095 wraps to 0; remaining count -1.
  - If remaining becomes 0 go to DN, else go to RD.
- DN (1 cycle): done=1, busy=1. Go to IDLE.
- Timing:
  - busy is high from the cycle after an accepted start through DN inclusive.
  - Per word: 2+READ_LATENCY cycles.
  - Total time from start to done: len*(2+READ_LATENCY)+1 cycles. At default READ_LATENCY=1, len=4 gives done in cycle 13 after start.
- Overlap: copying proceeds in ascending addresses, and each read follows the previous write.
  - If dst is in (src, src+len), the leading words replicate forward. This is defined and tested behaviour.
  - src==dst is legal; the data is unchanged.
- len_words > 4096 is truncated to its low ADDR_W+1 bits as given. A value of exactly 4096 copies the whole RAM.
- m_byteenable is constant all ones. No partial-word transfers.
- When m_chipselect=0, m_write is 0. m_address and m_writedata hold their last values.

Optional Feature:
- Macro: PLATFORM_RAM_COPIER_CHECKSUM_EN.
- Defined:
  - checksum is cleared to 0 on an accepted start.
  - checksum ^= the written word on each WR cycle.
  - The value is stable from DN until the next start.
- Undefined: checksum is tied to 0 and there is no checksum register.

Decomposition:
- Package platform_copier_pkg holds:
  - FSM state enum {IDLE, RD, WT, WR, DN};
  - localparams ADDR_W_DEF=12, DATA_W_DEF=32 and BE_ALL_ONES.
- No sub-module. Counters and the datapath stay inline in one module.

Test Plan:
- Basic copy: preload words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start src=0 dst=100 len=4 → words 100..103 match, done at cycle 13, busy low at cycle 14.
- Zero length: len=0 → done pulses on the cycle after start; no chipselect ever asserted.
- Wrap-around: src=4094 dst=10 len=4 → reads 4094, 4095, 0, 1 land at 10..13.
- Overlap: words 0..1 = 0xA, 0xB; src=0 dst=1 len=3 → words 1..3 all equal 0xA.
- Reset mid-transfer: assert reset in WT of word 2 (len=8) → next cycle busy=0, chipselect=0, no done; a following start completes normally.
- Checksum (macro defined): copy 0x0F0F0F0F, 0xFFFF0000 → checksum=0xF0F00F0F after done. A start while busy is ignored and the checksum is unaffected.
